uart_rx_buffer: RTL and testbench
=================================

// Module: uart_rx_buffer
// PURPOSE
//  Upstream feeder for the BPSK transmitter. Deserialises 8N1 UART bytes from uart_txd_in.
//  Buffers them in a small FWFT FIFO and presents them on a valid/ready byte stream to the modulator.
//  Also reports line activity so the transmitter can decide when to sleep.
// PARAMETERS
//  CLK_HZ       100_000_000  sysclk frequency
//  BAUD         115_200      UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, must be >= 4)
//  FIFO_DEPTH   16           byte entries; power of two, >= 2
// PORTS
//  sysclk       in   1                 single clock, all logic rising-edge
//  rst_n        in   1                 synchronous reset, active-low
//  uart_txd_in  in   1                 async serial line, idle high
//  m_data       out  8                 head-of-FIFO byte
//  m_valid      out  1                 m_data valid (FIFO not empty)
//  m_ready      in   1                 consumer accepts byte when m_valid & m_ready
//  fifo_level   out  $clog2(DEPTH)+1   current occupancy 0..FIFO_DEPTH
//  rx_busy      out  1                 high in any non-IDLE state
//  frame_err    out  1                 1-cycle pulse: stop bit sampled low
//  overflow     out  1                 1-cycle pulse: completed byte dropped, FIFO full
// BEHAVIOUR
//  - Reset (rst_n low at edge): FSM=IDLE, counters 0, FIFO empty.
//    Outputs: m_valid=0, m_data=0, fifo_level=0, rx_busy=0, frame_err=0, overflow=0.
//    Synchroniser flops reset to 1.
//  - Reset mid-frame aborts the partial byte. FIFO contents are discarded.
//  - uart_txd_in passes a 2-flop synchroniser (rx_s); all decisions use rx_s.
//  - FSM: IDLE -> START -> DATA -> STOP -> (IDLE | BREAK).
//    IDLE: on rx_s==0 go START and clear the bit counter.
//    START: after CLKS_PER_BIT/2 cycles sample rx_s.
//      If 1: false start, back to IDLE with no pulse.
//      Else: go DATA.
//    DATA: sample every CLKS_PER_BIT cycles (mid-bit), LSB first, into a shift register.
//      Go STOP after the 8th sample.
//    STOP: sample once after CLKS_PER_BIT cycles.
//      If 1: push the byte; go IDLE.
//      If 0: pulse frame_err, drop the byte, go BREAK.
//    BREAK: wait for rx_s==1, then IDLE (no re-trigger on a held-low line).
//  - Push happens in the stop-sample cycle. m_valid rises the next cycle if the FIFO was empty.
//  - Push when full (and no pop that cycle): byte dropped, overflow pulses, FIFO unchanged.
//  - Push and pop in the same cycle:
//    Always both performed, including when full (the pop frees the slot).
//    fifo_level is unchanged.
//  - Pop = m_valid & m_ready. m_data/m_valid change only on pop or push.
//    m_data is stable while m_valid & !m_ready.
//  - Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo depth.
//    Full/empty are decided from fifo_level, not pointer equality.
//  - Bit counter is 3 bits. The baud counter is $clog2(CLKS_PER_BIT) bits and reloads to 0 at terminal count.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    Frame is 8E1. A PARITY state sits between DATA and STOP and samples the 9th bit.
//    If the XOR of the 8 data bits and the parity bit is 1, the byte is dropped with a frame_err pulse.
//    The FSM still completes STOP normally.
//  UART_RX_PARITY_EN undefined:
//    Frame is 8N1. No PARITY state and no parity logic.
// STRUCTURE
//  Package bpsk_pkg:
//    uart_rx_state_e enum {IDLE, START, DATA, PARITY, STOP, BREAK};
//    function clks_per_bit(clk_hz, baud); localparam UART_DATA_BITS = 8.
//  Sub-module byte_fifo (FWFT, params DEPTH/WIDTH):
//    ports sysclk, rst_n, wr_en, wr_data, rd_en, rd_data, empty, full, level.
//  Top holds the synchroniser, the FSM and the baud/bit counters.
// TESTING (bench overrides CLK_HZ=800, BAUD=100 -> CLKS_PER_BIT=8)
//  1. Send 0xA5, m_ready=1 -> m_valid pulses 1 cycle with m_data=0xA5.
//     m_valid rises one cycle after the stop mid-sample; frame_err=0, overflow=0.
//  2. m_ready=0, send 17 bytes 0x00..0x10 -> fifo_level reaches 16.
//     overflow pulses once on byte 0x10. Draining then yields 0x00..0x0F in order and m_valid falls.
//  3. Low glitch of 3 cycles on idle line -> START aborts, back to IDLE.
//     No push, no frame_err; rx_busy high for at most 6 cycles.
//  4. Send 0x3C with stop bit forced 0 and line held low 40 cycles -> frame_err pulses once.
//     No push; FSM stays in BREAK until the line goes high, then 0x55 is received correctly.
//  5. FIFO full, m_ready=1 in the stop-sample cycle of a new byte (0xEE) -> pop and push both occur.
//     overflow=0, level stays 16, 0xEE is last out.
//  6. rst_n low for 1 cycle during DATA of 0x81 -> all outputs at reset values next cycle.
//     No byte is output from the aborted frame.
//  Parity build: send 0x07 with parity 1 -> byte accepted.
//    Send 0x07 with parity 0 -> frame_err, dropped.

Source files
------------

// File: rtl/bpsk_pkg.sv
// bpsk_pkg: shared types and helpers for the BPSK transmit chain front end.
package bpsk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_e;

    localparam int unsigned UART_DATA_BITS = 8;

    // Integer number of sysclk cycles per UART bit.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: first-word-fall-through FIFO. Occupancy is tracked by an explicit
// level counter, and full/empty are derived from that counter. The output reads
// as zero while the FIFO is empty.
module byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     sysclk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_rd;
    logic             w_do_wr;

    assign empty   = (r_level == '0);
    assign full    = (r_level == LVL_W'(DEPTH));
    assign level   = r_level;
    assign w_do_rd = rd_en & ~empty;
    // A read in the same cycle frees a slot, so a write into a full FIFO is still taken.
    assign w_do_wr = wr_en & (~full | w_do_rd);
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; stale contents are irrelevant because the pointers and level are reset.
    always_ff @(posedge sysclk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: UART receiver (8N1) feeding a byte FIFO that presents a
// valid/ready stream to the BPSK modulator, and reporting line activity.
// Build macro UART_RX_PARITY_EN selects 8E1 framing with a parity check.
module uart_rx_buffer
    import bpsk_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          sysclk,
    input  logic                          rst_n,
    input  logic                          uart_txd_in,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          rx_busy,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int unsigned CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CPB - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      r_sync1;
    logic                      r_sync2;
    logic                      w_rx_s;
    uart_rx_state_e            r_state;
    uart_rx_state_e            w_state_next;
    logic [CNT_W-1:0]          r_baud_cnt;
    logic [2:0]                r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      w_tick;
    logic                      w_push;
    logic                      w_ferr;
    logic                      w_pop;
    logic                      w_fifo_empty;
    logic                      w_fifo_full;
    logic                      r_frame_err;
    logic                      r_overflow;
`ifdef UART_RX_PARITY_EN
    logic                      r_par_bad;
`endif

    assign w_rx_s    = r_sync2;
    assign w_pop     = ~w_fifo_empty & m_ready;
    assign m_valid   = ~w_fifo_empty;
    assign rx_busy   = (r_state != IDLE);
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_txd_in;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus push/frame-error strobes at the sample points.
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_ferr       = 1'b0;
        w_tick       = (r_state == START) ? (r_baud_cnt == HALF_LAST)
                                          : (r_baud_cnt == FULL_LAST);
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tick && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
                        w_push = ~r_par_bad;
                        w_ferr = r_par_bad;
`else
                        w_push = 1'b1;
`endif
                        w_state_next = IDLE;
                    end else begin
                        w_ferr       = 1'b1;
                        w_state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Baud/bit counters and the LSB-first shift register.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            if ((r_state == IDLE) || (r_state == BREAK) || w_tick) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + CNT_W'(1);
            end
            if (r_state == IDLE) begin
                r_bit_cnt <= '0;
            end else if ((r_state == DATA) && w_tick) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even-parity check: the data bits XOR the parity bit must be zero.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_par_bad <= 1'b0;
        end else if (r_state == IDLE) begin
            r_par_bad <= 1'b0;
        end else if ((r_state == PARITY) && w_tick) begin
            r_par_bad <= (^r_shift) ^ w_rx_s;
        end
    end
`endif

    // One-cycle status pulses, aligned with the FIFO update of the stop sample.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overflow  <= w_push & w_fifo_full & ~w_pop;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .wr_en   (w_push),
        .wr_data (r_shift),
        .rd_en   (w_pop),
        .rd_data (m_data),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full),
        .level   (fifo_level)
    );

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: directed scenarios plus randomized frames for uart_rx_buffer,
// checked every cycle against a queue-based model of the receive path.
module tb_uart_rx_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CPB   = 8;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NPAR = 1;
`else
    localparam int unsigned NPAR = 0;
`endif
    // Line edge to FIFO update: 2 sync flops + idle detect, half bit, then
    // data/parity/stop bits each one full bit.
    localparam int unsigned PUSH_LAT = 3 + CPB / 2 + (9 + NPAR) * CPB;

    logic       sysclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_txd_in = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic [4:0] fifo_level;
    logic       rx_busy;
    logic       frame_err;
    logic       overflow;

    always #5 sysclk = ~sysclk;

    uart_rx_buffer #(
        .CLK_HZ     (800),
        .BAUD       (100),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .uart_txd_in (uart_txd_in),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .fifo_level  (fifo_level),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
        .overflow    (overflow)
    );

    typedef struct {
        int unsigned at;
        bit          is_push;
        logic [7:0]  data;
    } ev_t;

    ev_t         ev_q[$];
    logic [7:0]  model_q[$];
    logic [7:0]  out_q[$];
    bit          exp_ferr = 1'b0;
    bit          exp_ovf = 1'b0;
    bit          check_en = 1'b0;
    bit          rand_on = 1'b0;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          ferr_cnt = 0;
    int          ovf_cnt = 0;
    int          busy_cnt = 0;
    int          valid_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wc(input int unsigned n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    // Drive one frame and schedule what the receiver must do at its stop sample.
    task automatic send(input logic [7:0] b, input bit stop_v, input bit par_flip,
                        input int unsigned hold, input bit ready_pulse);
        ev_t e;
        e.at      = cyc + PUSH_LAT;
        e.is_push = stop_v && !par_flip;
        e.data    = b;
        ev_q.push_back(e);
        uart_txd_in = 1'b0;
        wc(CPB);
        for (int unsigned i = 0; i < 8; i++) begin
            uart_txd_in = b[i];
            wc(CPB);
        end
`ifdef UART_RX_PARITY_EN
        uart_txd_in = (^b) ^ par_flip;
        wc(CPB);
`endif
        uart_txd_in = stop_v;
        if (ready_pulse) begin
            wc(CPB - 2);
            m_ready = 1'b1;
            wc(1);
            m_ready = 1'b0;
            wc(1);
        end else begin
            wc(CPB);
        end
        if (hold > 0) wc(hold);
        uart_txd_in = 1'b1;
    endtask

    // Reference model: FIFO as a queue, frames as scheduled push/error events.
    initial begin
        bit pop;
        forever begin
            @(posedge sysclk);
            cyc++;
            if (!rst_n) begin
                model_q.delete();
                ev_q.delete();
                exp_ferr = 1'b0;
                exp_ovf  = 1'b0;
            end else begin
                pop      = (model_q.size() != 0) && m_ready;
                exp_ferr = 1'b0;
                exp_ovf  = 1'b0;
                if (pop) void'(model_q.pop_front());
                while (ev_q.size() != 0 && ev_q[0].at <= cyc) begin
                    if (ev_q[0].at == cyc) begin
                        if (ev_q[0].is_push) begin
                            if (model_q.size() < DEPTH) model_q.push_back(ev_q[0].data);
                            else exp_ovf = 1'b1;
                        end else begin
                            exp_ferr = 1'b1;
                        end
                    end
                    void'(ev_q.pop_front());
                end
            end
        end
    end

    // Per-cycle compare against the model, plus event tallies for the directed checks.
    initial begin
        forever begin
            @(negedge sysclk);
            if (check_en) begin
                chk("m_valid", 32'(m_valid), 32'(model_q.size() != 0));
                chk("m_data", 32'(m_data), (model_q.size() != 0) ? 32'(model_q[0]) : 32'd0);
                chk("fifo_level", 32'(fifo_level), 32'(model_q.size()));
                chk("frame_err", 32'(frame_err), 32'(exp_ferr));
                chk("overflow", 32'(overflow), 32'(exp_ovf));
                if (m_valid === 1'b1 && m_ready === 1'b1) out_q.push_back(m_data);
                if (frame_err === 1'b1) ferr_cnt++;
                if (overflow === 1'b1) ovf_cnt++;
                if (rx_busy === 1'b1) busy_cnt++;
                if (m_valid === 1'b1) valid_cnt++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit         sbad;
        rst_n = 1'b0;
        wc(3);
        rst_n = 1'b1;
        check_en = 1'b1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // 1: single byte, consumer always ready
        m_ready = 1'b1;
        out_q.delete(); valid_cnt = 0; ferr_cnt = 0; ovf_cnt = 0;
        send(8'hA5, 1'b1, 1'b0, 0, 1'b0);
        wc(6);
        chk("t1_count", 32'(out_q.size()), 32'd1);
        chk("t1_data", (out_q.size() != 0) ? 32'(out_q[0]) : 32'hDEAD, 32'h0A5);
        chk("t1_valid_cycles", 32'(valid_cnt), 32'd1);
        chk("t1_ferr", 32'(ferr_cnt), 32'd0);
        chk("t1_ovf", 32'(ovf_cnt), 32'd0);

        // 2: fill past capacity, then drain
        m_ready = 1'b0;
        ovf_cnt = 0;
        for (int unsigned i = 0; i < 17; i++) send(8'(i), 1'b1, 1'b0, 0, 1'b0);
        wc(2);
        chk("t2_level", 32'(fifo_level), 32'd16);
        chk("t2_ovf_pulses", 32'(ovf_cnt), 32'd1);
        out_q.delete();
        m_ready = 1'b1;
        wc(20);
        m_ready = 1'b0;
        chk("t2_drain_count", 32'(out_q.size()), 32'd16);
        for (int unsigned i = 0; i < 16 && i < out_q.size(); i++) chk("t2_drain_data", 32'(out_q[i]), i);
        chk("t2_valid_low", 32'(m_valid), 32'd0);

        // 3: short low glitch is a false start
        m_ready = 1'b1;
        busy_cnt = 0; ferr_cnt = 0; out_q.delete();
        uart_txd_in = 1'b0;
        wc(3);
        uart_txd_in = 1'b1;
        wc(12);
        chk("t3_busy_le6", 32'(busy_cnt <= 6), 32'd1);
        chk("t3_busy_seen", 32'(busy_cnt > 0), 32'd1);
        chk("t3_no_push", 32'(out_q.size()), 32'd0);
        chk("t3_no_ferr", 32'(ferr_cnt), 32'd0);

        // 4: bad stop bit with line held low, then recovery
        ferr_cnt = 0; out_q.delete();
        send(8'h3C, 1'b0, 1'b0, 40, 1'b0);
        chk("t4_break_busy", 32'(rx_busy), 32'd1);
        wc(16);
        chk("t4_idle", 32'(rx_busy), 32'd0);
        chk("t4_ferr_pulses", 32'(ferr_cnt), 32'd1);
        chk("t4_no_push", 32'(out_q.size()), 32'd0);
        send(8'h55, 1'b1, 1'b0, 0, 1'b0);
        wc(6);
        chk("t4_next_count", 32'(out_q.size()), 32'd1);
        chk("t4_next_data", (out_q.size() != 0) ? 32'(out_q[0]) : 32'hDEAD, 32'h055);

        // 5: full FIFO, pop coincides with the push of a new byte
        m_ready = 1'b0;
        for (int unsigned i = 0; i < 16; i++) send(8'(8'h30 + i), 1'b1, 1'b0, 0, 1'b0);
        wc(2);
        chk("t5_full", 32'(fifo_level), 32'd16);
        ovf_cnt = 0; out_q.delete();
        send(8'hEE, 1'b1, 1'b0, 0, 1'b1);
        wc(2);
        chk("t5_ovf", 32'(ovf_cnt), 32'd0);
        chk("t5_level", 32'(fifo_level), 32'd16);
        chk("t5_popped", (out_q.size() != 0) ? 32'(out_q[0]) : 32'hDEAD, 32'h030);
        out_q.delete();
        m_ready = 1'b1;
        wc(20);
        m_ready = 1'b0;
        chk("t5_drain_count", 32'(out_q.size()), 32'd16);
        chk("t5_first", (out_q.size() != 0) ? 32'(out_q[0]) : 32'hDEAD, 32'h031);
        chk("t5_last", (out_q.size() == 16) ? 32'(out_q[15]) : 32'hDEAD, 32'h0EE);

        // 6: reset during the last data bit of 0x81 with bytes already buffered
        for (int unsigned i = 1; i <= 3; i++) send(8'(8'h11 * i), 1'b1, 1'b0, 0, 1'b0);
        wc(2);
        chk("t6_prefill", 32'(fifo_level), 32'd3);
        out_q.delete();
        fork
            send(8'h81, 1'b1, 1'b0, 0, 1'b0);
            begin
                wc(65);
                rst_n = 1'b0;
                wc(1);
                rst_n = 1'b1;
                chk("t6_m_valid", 32'(m_valid), 32'd0);
                chk("t6_m_data", 32'(m_data), 32'd0);
                chk("t6_level", 32'(fifo_level), 32'd0);
                chk("t6_busy", 32'(rx_busy), 32'd0);
                chk("t6_ferr", 32'(frame_err), 32'd0);
                chk("t6_ovf", 32'(overflow), 32'd0);
                m_ready = 1'b1;
            end
        join
        wc(20);
        chk("t6_no_output", 32'(out_q.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
        // parity: good then bad parity on the same byte
        m_ready = 1'b1;
        ferr_cnt = 0; out_q.delete();
        send(8'h07, 1'b1, 1'b0, 0, 1'b0);
        send(8'h07, 1'b1, 1'b1, 0, 1'b0);
        wc(6);
        chk("par_count", 32'(out_q.size()), 32'd1);
        chk("par_data", (out_q.size() != 0) ? 32'(out_q[0]) : 32'hDEAD, 32'h007);
        chk("par_ferr", 32'(ferr_cnt), 32'd1);
`endif

        // randomized frames, occasional bad stop bits, random consumer back-pressure
        rand_on = 1'b1;
        fork
            begin
                for (int unsigned k = 0; k < 40; k++) begin
                    b    = 8'($urandom);
                    sbad = ($urandom_range(0, 7) == 0);
                    send(b, !sbad, 1'b0, sbad ? $urandom_range(0, 20) : 0, 1'b0);
                    wc(1 + $urandom_range(0, 4));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    wc(1);
                    m_ready = 1'($urandom);
                end
            end
        join
        m_ready = 1'b1;
        wc(40);
        chk("end_empty", 32'(m_valid), 32'd0);
        chk("end_level", 32'(fifo_level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
